// File: rtl/wb_intercon_pipe.sv
// Pipelined Wishbone B4 interconnect: one master to NSLV slaves with base/mask decode,
// up to MAX_OUTST outstanding requests and an internal err responder; WB_TIMEOUT_EN adds a watchdog.
`timescale 1ns/1ps
`default_nettype none

module wb_intercon_pipe #(
    parameter int                  NSLV      = 4,
    parameter int                  AW        = 16,
    parameter int                  DW        = 16,
    parameter logic [NSLV*AW-1:0]  SLV_BASE  = {16'h6000, 16'h5000, 16'h4000, 16'h0000},
    parameter logic [NSLV*AW-1:0]  SLV_MASK  = {16'hF000, 16'hF000, 16'hF000, 16'hC000},
    parameter int                  MAX_OUTST = 4,
    parameter int                  TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_cyc,
    input  logic                 m_stb,
    input  logic                 m_we,
    input  logic [AW-1:0]        m_adr,
    input  logic [DW-1:0]        m_dat_i,
    output logic [DW-1:0]        m_dat_o,
    output logic                 m_ack,
    output logic                 m_err,
    output logic                 m_stall,
    output logic [NSLV-1:0]      s_cyc,
    output logic [NSLV-1:0]      s_stb,
    output logic [NSLV-1:0]      s_we,
    output logic [NSLV*AW-1:0]   s_adr,
    output logic [NSLV*DW-1:0]   s_dat_o,
    input  logic [NSLV*DW-1:0]   s_dat_i,
    input  logic [NSLV-1:0]      s_ack,
    input  logic [NSLV-1:0]      s_stall
);

    localparam int TW = $clog2(NSLV + 1);
    localparam int CW = $clog2(MAX_OUTST + 1);

    if (NSLV < 1 || NSLV > 8 || MAX_OUTST < 1 || MAX_OUTST > 15 || TIMEOUT < 1) begin : g_param_check
        $error("wb_intercon_pipe: parameter out of range");
    end

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   cur_tgt_q, cur_tgt_d;
    logic [TW-1:0]   tgt;
    logic [NSLV-1:0] hit;
    logic            req, busy, block, accept, resp;
    logic            tgt_stall, cur_ack, cur_mapped;
    logic [DW-1:0]   cur_dat;
    logic            timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_slv
            assign hit[gi]   = (m_adr & SLV_MASK[gi*AW +: AW]) == SLV_BASE[gi*AW +: AW];
            assign s_stb[gi] = req & (tgt == TW'(gi)) & ~block;
            assign s_cyc[gi] = m_cyc & ((req & (tgt == TW'(gi)) & ~block) |
                                        (busy & (cur_tgt_q == TW'(gi)) & ~timeout_hit));
            assign s_we[gi]                 = m_we;
            assign s_adr[gi*AW +: AW]       = m_adr;
            assign s_dat_o[gi*DW +: DW]     = m_dat_i;
        end
    endgenerate

    // Scan downwards so the lowest matching index wins; no hit leaves tgt = NSLV.
    always_comb begin
        tgt = TW'(NSLV);
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hit[i]) tgt = TW'(i);
        end
    end

    always_comb begin
        tgt_stall = 1'b0;
        cur_ack   = 1'b0;
        cur_dat   = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (tgt == TW'(i))       tgt_stall = s_stall[i];
            if (cur_tgt_q == TW'(i)) begin
                cur_ack = s_ack[i];
                cur_dat = s_dat_i[i*DW +: DW];
            end
        end
    end

    assign req        = m_cyc & m_stb;
    assign busy       = (cnt_q != '0);
    assign cur_mapped = (cur_tgt_q < TW'(NSLV));
    assign block      = (cnt_q == CW'(MAX_OUTST)) | (busy & (tgt != cur_tgt_q)) | timeout_hit;
    assign m_stall    = req & (block | tgt_stall);
    assign accept     = req & ~m_stall;

    // Responses are gated by m_cyc so an aborted cycle never sees a stray ack.
    assign m_ack   = m_cyc & busy & cur_mapped & cur_ack & ~timeout_hit;
    assign m_err   = m_cyc & busy & (~cur_mapped | timeout_hit);
    assign resp    = m_ack | m_err;
    assign m_dat_o = m_ack ? cur_dat : '0;

    always_comb begin
        cnt_d     = cnt_q;
        cur_tgt_d = cur_tgt_q;
        if (accept) cur_tgt_d = tgt;
        if (!m_cyc || timeout_hit) begin
            cnt_d = '0;
        end else if (accept && !resp) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && resp) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cur_tgt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cur_tgt_q <= cur_tgt_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wdog_q, wdog_d;

    // wdog_q counts silent cycles since the last accept/resp; the TIMEOUT-th one fires.
    assign timeout_hit = m_cyc & busy & (wdog_q == WW'(TIMEOUT - 1));

    always_comb begin
        wdog_d = wdog_q + WW'(1);
        if (!busy || !m_cyc || accept || resp || timeout_hit) wdog_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_intercon_pipe.sv
// Self-checking bench for wb_intercon_pipe: decode vector table, directed multi-cycle
// sequences, and randomized traffic against a queue-based transaction model.
`timescale 1ns/1ps

module tb_wb_intercon_pipe;

    localparam int NSLV = 4, AW = 16, DW = 16, MAX_OUTST = 4, TIMEOUT = 8;
    localparam logic [NSLV*AW-1:0] P_BASE = {16'h6000, 16'h5000, 16'h4000, 16'h0000};
    localparam logic [NSLV*AW-1:0] P_MASK = {16'hF000, 16'hF000, 16'hF000, 16'hC000};
    localparam logic [AW-1:0] BASE_A [NSLV] = '{16'h0000, 16'h4000, 16'h5000, 16'h6000};
    localparam logic [AW-1:0] MASK_A [NSLV] = '{16'hC000, 16'hF000, 16'hF000, 16'hF000};
    localparam logic [DW-1:0] SALT   [NSLV] = '{16'hBEFF, 16'h1234, 16'hA5A5, 16'h0F0F};

    logic clk = 1'b0;
    logic rst_n;
    logic m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat_i, m_dat_o;
    logic m_ack, m_err, m_stall;
    logic [NSLV-1:0] s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [NSLV*AW-1:0] s_adr;
    logic [NSLV*DW-1:0] s_dat_o, s_dat_i;

    always #5 clk = ~clk;

    wb_intercon_pipe #(
        .NSLV(NSLV), .AW(AW), .DW(DW), .SLV_BASE(P_BASE), .SLV_MASK(P_MASK),
        .MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack(s_ack), .s_stall(s_stall)
    );

    // Expected master-side responses, oldest first; its length is the outstanding count.
    typedef struct { int tgt; logic err; logic [DW-1:0] dat; } exp_t;
    // Requests a behavioural slave has accepted and will ack in order.
    typedef struct { int slv; int due; logic [DW-1:0] dat; } pend_t;
    typedef struct { logic [AW-1:0] adr; logic [NSLV-1:0] stall; logic [NSLV-1:0] stb; logic mstall; } vec_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    lat [NSLV];
    bit    hang [NSLV];
    logic [NSLV-1:0] force_ack, model_ack;
    bit    rand_stall_en;
    int    now, checks, errors, n_ack, n_err;

    function automatic int decode(logic [AW-1:0] a);
        for (int i = 0; i < NSLV; i++) if ((a & MASK_A[i]) == BASE_A[i]) return i;
        return NSLV;
    endfunction

    function automatic logic [DW-1:0] sdata(int i, logic [AW-1:0] a);
        return a ^ SALT[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic drive_slaves();
        logic [NSLV-1:0] a;
        logic [NSLV*DW-1:0] d;
        bit found;
        a = '0;
        d = '0;
        for (int i = 0; i < NSLV; i++) begin
            found = 0;
            d[i*DW +: DW] = ~SALT[i];
            for (int j = 0; j < pend_q.size(); j++) begin
                if (!found && pend_q[j].slv == i) begin
                    found = 1;
                    if (pend_q[j].due <= now) begin
                        a[i] = 1'b1;
                        d[i*DW +: DW] = pend_q[j].dat;
                    end
                end
            end
        end
        model_ack = a;
        s_ack     = a | force_ack;
        s_dat_i   = d;
    endtask

    // Observe the settled cycle, update the models, then advance one clock.
    task automatic tick();
        exp_t e;
        pend_t p;
        int t;
        bit found;
        #1;
        if (m_ack || m_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {30'd0, m_ack, m_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_kind", {30'd0, m_ack, m_err}, e.err ? 32'd1 : 32'd2);
                if (!e.err) chk("resp_data", m_dat_o, e.dat);
                if (m_ack) n_ack++;
                if (m_err) n_err++;
                $display("resp t=%0d slave=%0d %s dat=%h", now, e.tgt, m_err ? "err" : "ack", m_dat_o);
            end
        end
        if (!m_ack) chk("dat_idle_zero", m_dat_o, 32'd0);
        if (m_cyc && m_stb && !m_stall) begin
            t = decode(m_adr);
            e.tgt = t;
            e.err = (t == NSLV);
`ifdef WB_TIMEOUT_EN
            if (t < NSLV && hang[t]) e.err = 1'b1;
`endif
            e.dat = (t < NSLV) ? sdata(t, m_adr) : '0;
            exp_q.push_back(e);
        end
        if (!m_cyc) exp_q.delete();
        for (int i = 0; i < NSLV; i++) begin
            if (model_ack[i]) begin
                found = 0;
                for (int j = 0; j < pend_q.size(); j++)
                    if (!found && pend_q[j].slv == i) begin found = 1; pend_q.delete(j); end
            end
            if (!s_cyc[i]) begin
                for (int j = pend_q.size() - 1; j >= 0; j--)
                    if (pend_q[j].slv == i) pend_q.delete(j);
            end
            if (s_cyc[i] && s_stb[i] && !s_stall[i]) begin
                chk("bcast_adr", s_adr[i*AW +: AW], m_adr);
                chk("bcast_dat", s_dat_o[i*DW +: DW], m_dat_i);
                chk("bcast_we", s_we[i], m_we);
                if (!hang[i]) begin
                    p.slv = i;
                    p.due = now + lat[i];
                    p.dat = sdata(i, s_adr[i*AW +: AW]);
                    pend_q.push_back(p);
                end
            end
        end
        @(posedge clk);
        #1;
        now++;
        drive_slaves();
        if (rand_stall_en) s_stall = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        @(negedge clk);
    endtask

    task automatic drain();
        int b;
        m_stb = 1'b0;
        b = 0;
        while (exp_q.size() != 0 && b < 60) begin
            tick();
            b++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    vec_t vt [10];
    int   k, base_ack, resp_seen;
    bit   held;
    int   t_r, n_r;
    bit   blk_r;
    logic [NSLV-1:0] stb_r, cyc_r;

    initial begin
        checks = 0; errors = 0; now = 0; n_ack = 0; n_err = 0;
        rst_n = 1'b0; m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat_i = '0;
        s_ack = '0; s_stall = '0; s_dat_i = '0; force_ack = '0; model_ack = '0;
        rand_stall_en = 0;
        for (int i = 0; i < NSLV; i++) begin lat[i] = 1; hang[i] = 0; end

        vt[0] = '{16'h0010, 4'b0000, 4'b0001, 1'b0};
        vt[1] = '{16'h3FFF, 4'b0000, 4'b0001, 1'b0};
        vt[2] = '{16'h4000, 4'b0000, 4'b0010, 1'b0};
        vt[3] = '{16'h4FFF, 4'b0010, 4'b0010, 1'b1};
        vt[4] = '{16'h5000, 4'b1011, 4'b0100, 1'b0};
        vt[5] = '{16'h5ABC, 4'b0100, 4'b0100, 1'b1};
        vt[6] = '{16'h6000, 4'b0000, 4'b1000, 1'b0};
        vt[7] = '{16'h7000, 4'b1111, 4'b0000, 1'b0};
        vt[8] = '{16'h8000, 4'b1111, 4'b0000, 1'b0};
        vt[9] = '{16'hC000, 4'b0000, 4'b0000, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_m_stall", m_stall, 0);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        rst_n = 1'b1;
        tick();

        // Decode table from idle.
        for (int v = 0; v < 10; v++) begin
            m_cyc = 1; m_stb = 1; m_adr = vt[v].adr; s_stall = vt[v].stall;
            #1;
            $display("vec %0d adr=%h s_stb=%b m_stall=%b", v, m_adr, s_stb, m_stall);
            chk("vec_s_stb", s_stb, vt[v].stb);
            chk("vec_s_cyc", s_cyc, vt[v].stb);
            chk("vec_m_stall", m_stall, vt[v].mstall);
            chk("vec_no_resp", {m_ack, m_err}, 0);
            m_stb = 0; m_cyc = 0; s_stall = '0;
            tick();
        end

        // Single read from slave 0.
        lat[0] = 1;
        m_cyc = 1; m_stb = 1; m_we = 0; m_adr = 16'h0010;
        #1;
        chk("rd0_s_stb", s_stb, 4'b0001);
        chk("rd0_stall", m_stall, 0);
        tick();
        m_stb = 0;
        #1;
        chk("rd0_ack", m_ack, 1);
        chk("rd0_data", m_dat_o, 16'hBEEF);
        chk("rd0_err", m_err, 0);
        chk("rd0_stb_once", s_stb, 0);
        tick();
        #1;
        chk("rd0_ack_gone", m_ack, 0);
        chk("rd0_cnt_zero", s_cyc, 0);

        // Four back-to-back reads to a slow slave, fifth one stalls.
        lat[1] = 5;
        base_ack = n_ack;
        for (int i = 0; i < 4; i++) begin
            m_stb = 1; m_adr = 16'h4000 + 16'(i);
            #1;
            chk("b2b_nostall", m_stall, 0);
            tick();
        end
        m_adr = 16'h4004;
        #1;
        k = 0;
        while (m_stall && k < 20) begin k++; tick(); #1; end
        chk("b2b_stall_cycles", k, 2);
        tick();
        drain();
        chk("b2b_ack_count", n_ack - base_ack, 5);

        // Target switch waits for the previous slave to finish.
        lat[1] = 3;
        m_stb = 1; m_adr = 16'h4000;
        #1;
        chk("sw_first_nostall", m_stall, 0);
        tick();
        m_adr = 16'h5000;
        #1;
        chk("sw_blocked_stb", s_stb, 0);
        k = 0;
        while (m_stall && k < 20) begin k++; tick(); #1; end
        chk("sw_stall_cycles", k, 3);
        chk("sw_issued_stb", s_stb, 4'b0100);
        tick();
        drain();

        // Unmapped write answered by the internal err responder.
        base_ack = n_ack;
        m_stb = 1; m_we = 1; m_adr = 16'h8000; m_dat_i = 16'h1234;
        #1;
        chk("unm_no_stb", s_stb, 0);
        chk("unm_nostall", m_stall, 0);
        tick();
        m_stb = 0; m_we = 0;
        #1;
        chk("unm_err", m_err, 1);
        chk("unm_no_ack", m_ack, 0);
        tick();
        #1;
        chk("unm_err_once", m_err, 0);
        chk("unm_ack_count", n_ack - base_ack, 0);

        // Abort with two outstanding; a late ack must be discarded.
        lat[1] = 6;
        for (int i = 0; i < 2; i++) begin
            m_stb = 1; m_adr = 16'h4010 + 16'(i);
            tick();
        end
        m_cyc = 0; m_stb = 0;
        #1;
        chk("abort_scyc_drop", s_cyc, 0);
        tick();
        m_cyc = 1; force_ack = 4'b0010;
        drive_slaves();
        #1;
        chk("abort_late_ack", m_ack, 0);
        chk("abort_cnt_zero", s_cyc, 0);
        force_ack = '0;
        tick();
        m_stb = 1; m_adr = 16'h5000;
        #1;
        chk("abort_new_nostall", m_stall, 0);
        chk("abort_new_stb", s_stb, 4'b0100);
        tick();
        drain();

        // Reset in the middle of an outstanding read clears the tracker.
        m_stb = 1; m_adr = 16'h4020;
        tick();
        m_stb = 0; rst_n = 0;
        tick();
        rst_n = 1;
        exp_q.delete();
        m_stb = 1; m_adr = 16'h5004;
        #1;
        chk("midrst_nostall", m_stall, 0);
        chk("midrst_stb", s_stb, 4'b0100);
        tick();
        drain();

        // Slave 3 never answers.
        hang[3] = 1;
        m_stb = 1; m_adr = 16'h6000;
        #1;
        chk("hang_accept", m_stall, 0);
        tick();
        m_stb = 0;
`ifdef WB_TIMEOUT_EN
        k = 1;
        #1;
        while (!m_err && k < 30) begin tick(); #1; k++; end
        chk("timeout_cycles", k, TIMEOUT);
        chk("timeout_no_ack", m_ack, 0);
        chk("timeout_scyc_low", s_cyc, 0);
        tick();
        #1;
        chk("timeout_err_once", m_err, 0);
        chk("timeout_cnt_zero", s_cyc, 0);
`else
        resp_seen = 0;
        repeat (20) begin
            #1;
            if (m_ack || m_err) resp_seen++;
            tick();
        end
        chk("hang_no_resp", resp_seen, 0);
        m_stb = 1; m_adr = 16'h0010;
        #1;
        chk("hang_blocks_other", m_stall, 1);
        m_stb = 0; m_cyc = 0;
        tick();
        m_cyc = 1;
`endif
        hang[3] = 0;

        // Randomized traffic against the transaction model.
        for (int i = 0; i < NSLV; i++) lat[i] = $urandom_range(1, 4);
        rand_stall_en = 1;
        m_cyc = 1; m_stb = 0;
        held = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!held) begin
                m_stb = ($urandom_range(0, 9) < 7);
                m_we = 1'($urandom_range(0, 1));
                m_dat_i = 16'($urandom);
                case ($urandom_range(0, 5))
                    0: m_adr = {2'b00, 14'($urandom)};
                    1: m_adr = 16'h4000 | 16'($urandom_range(0, 16'h0FFF));
                    2: m_adr = 16'h5000 | 16'($urandom_range(0, 16'h0FFF));
                    3: m_adr = 16'h6000 | 16'($urandom_range(0, 16'h0FFF));
                    4: m_adr = 16'h7000 | 16'($urandom_range(0, 16'h0FFF));
                    default: m_adr = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                endcase
            end
            #1;
            t_r = decode(m_adr);
            n_r = exp_q.size();
            blk_r = (n_r == MAX_OUTST) || (n_r != 0 && exp_q[0].tgt != t_r);
            stb_r = (m_stb && !blk_r && t_r < NSLV) ? NSLV'(1 << t_r) : '0;
            cyc_r = stb_r;
            if (n_r != 0 && exp_q[0].tgt < NSLV) cyc_r = cyc_r | NSLV'(1 << exp_q[0].tgt);
            chk("rand_stall", m_stall, m_stb && (blk_r || (t_r < NSLV && s_stall[t_r])));
            chk("rand_stb", s_stb, stb_r);
            chk("rand_cyc", s_cyc, cyc_r);
            held = m_stb && m_stall;
            tick();
        end
        rand_stall_en = 0;
        s_stall = '0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
